vga_control: RTL and testbench

VGA_CONTROL -- requirements
Module: vga_control

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_config.sv | 95 +++++++++
 rtl/vga_control.sv | 112 +++++++++++
 tb/tb_vga_control.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA controller: widths, register map, reset defaults.
// VGA_TEST_PATTERN_EN adds the control register at CTRL_ADDR.
package vga_pkg;

    localparam int CONFIG_WIDTH = 4;
    localparam int DATA_WIDTH   = 12;
    localparam int COLOR_WIDTH  = 4;

    typedef logic [CONFIG_WIDTH-1:0] cfg_t;

    localparam int TIMING_REGS  = 8;
    localparam int H_LEFT_ADDR  = 0;
    localparam int V_LEFT_ADDR  = 1;
    localparam int H_RIGHT_ADDR = 2;
    localparam int V_RIGHT_ADDR = 3;
    localparam int H_SYNC_ADDR  = 4;
    localparam int V_SYNC_ADDR  = 5;
    localparam int H_MAX_ADDR   = 6;
    localparam int V_MAX_ADDR   = 7;
    localparam int CTRL_ADDR    = 8;

    localparam cfg_t H_LEFT_MARGIN_RD  = 4'd1;
    localparam cfg_t V_LEFT_MARGIN_RD  = 4'd2;
    localparam cfg_t H_RIGHT_MARGIN_RD = 4'd7;
    localparam cfg_t V_RIGHT_MARGIN_RD = 4'd8;
    localparam cfg_t H_SYNC_PULSE_RD   = 4'd1;
    localparam cfg_t V_SYNC_PULSE_RD   = 4'd0;
    localparam cfg_t H_COUNT_MAX_RD    = 4'd10;
    localparam cfg_t V_COUNT_MAX_RD    = 4'd12;

endpackage

// File: rtl/vga_config.sv
// Pending/active timing registers and config-port handshake.
// VGA_TEST_PATTERN_EN adds the immediate-effect pattern enable bit.
module vga_config #(
    parameter int CONFIG_WIDTH = vga_pkg::CONFIG_WIDTH,
    parameter logic [CONFIG_WIDTH-1:0] H_Left_Margin_RD  = CONFIG_WIDTH'(vga_pkg::H_LEFT_MARGIN_RD),
    parameter logic [CONFIG_WIDTH-1:0] V_Left_Margin_RD  = CONFIG_WIDTH'(vga_pkg::V_LEFT_MARGIN_RD),
    parameter logic [CONFIG_WIDTH-1:0] H_Right_Margin_RD = CONFIG_WIDTH'(vga_pkg::H_RIGHT_MARGIN_RD),
    parameter logic [CONFIG_WIDTH-1:0] V_Right_Margin_RD = CONFIG_WIDTH'(vga_pkg::V_RIGHT_MARGIN_RD),
    parameter logic [CONFIG_WIDTH-1:0] H_Sync_Pulse_RD   = CONFIG_WIDTH'(vga_pkg::H_SYNC_PULSE_RD),
    parameter logic [CONFIG_WIDTH-1:0] V_Sync_Pulse_RD   = CONFIG_WIDTH'(vga_pkg::V_SYNC_PULSE_RD),
    parameter logic [CONFIG_WIDTH-1:0] H_Count_Max_RD    = CONFIG_WIDTH'(vga_pkg::H_COUNT_MAX_RD),
    parameter logic [CONFIG_WIDTH-1:0] V_Count_Max_RD    = CONFIG_WIDTH'(vga_pkg::V_COUNT_MAX_RD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    c_valid,
    input  logic [CONFIG_WIDTH-1:0] c_addr,
    input  logic [CONFIG_WIDTH-1:0] c_data,
    input  logic                    frame_end,
    output logic                    c_rdy,
    output logic [CONFIG_WIDTH-1:0] h_left,
    output logic [CONFIG_WIDTH-1:0] v_left,
    output logic [CONFIG_WIDTH-1:0] h_right,
    output logic [CONFIG_WIDTH-1:0] v_right,
    output logic [CONFIG_WIDTH-1:0] h_sync,
    output logic [CONFIG_WIDTH-1:0] v_sync,
    output logic [CONFIG_WIDTH-1:0] h_max,
`ifdef VGA_TEST_PATTERN_EN
    output logic                    pat_en,
`endif
    output logic [CONFIG_WIDTH-1:0] v_max
);
    import vga_pkg::*;

    logic [TIMING_REGS-1:0][CONFIG_WIDTH-1:0] rd_val;
    logic [TIMING_REGS-1:0][CONFIG_WIDTH-1:0] pend;
    logic [TIMING_REGS-1:0][CONFIG_WIDTH-1:0] act;
    logic dirty;
    logic wr;
    logic wr_map;

    assign rd_val = {V_Count_Max_RD, H_Count_Max_RD,
                     V_Sync_Pulse_RD, H_Sync_Pulse_RD,
                     V_Right_Margin_RD, H_Right_Margin_RD,
                     V_Left_Margin_RD, H_Left_Margin_RD};

    assign wr     = c_valid && c_rdy;
    assign wr_map = wr && (c_addr < CONFIG_WIDTH'(TIMING_REGS));

    // A write that collides with the frame end stays pending for one more frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= rd_val;
            act   <= rd_val;
            dirty <= 1'b0;
            c_rdy <= 1'b0;
        end else begin
            if (frame_end) begin
                act <= pend;
            end
            if (wr_map) begin
                pend[c_addr[2:0]] <= c_data;
                dirty             <= 1'b1;
                c_rdy             <= 1'b0;
            end else if (dirty) begin
                if (frame_end) begin
                    dirty <= 1'b0;
                    c_rdy <= 1'b1;
                end
            end else begin
                c_rdy <= 1'b1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_en <= 1'b0;
        end else if (wr && c_addr == CONFIG_WIDTH'(CTRL_ADDR)) begin
            pat_en <= c_data[0];
        end
    end
`endif

    assign h_left  = act[H_LEFT_ADDR];
    assign v_left  = act[V_LEFT_ADDR];
    assign h_right = act[H_RIGHT_ADDR];
    assign v_right = act[V_RIGHT_ADDR];
    assign h_sync  = act[H_SYNC_ADDR];
    assign v_sync  = act[V_SYNC_ADDR];
    assign h_max   = act[H_MAX_ADDR];
    assign v_max   = act[V_MAX_ADDR];

endmodule

// File: rtl/vga_control.sv
// VGA timing generator with registered sync and colour outputs.
// Define VGA_TEST_PATTERN_EN to add the h/v test-pattern source.
module vga_control #(
    parameter int CONFIG_WIDTH = vga_pkg::CONFIG_WIDTH,
    parameter int DATA_WIDTH   = vga_pkg::DATA_WIDTH,
    parameter int COLOR_WIDTH  = vga_pkg::COLOR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    C_valid,
    input  logic [CONFIG_WIDTH-1:0] C_addr,
    input  logic [CONFIG_WIDTH-1:0] C_data,
    input  logic [DATA_WIDTH-1:0]   Data_in,
    output logic                    C_rdy,
    output logic                    HSync,
    output logic                    VSync,
    output logic [COLOR_WIDTH-1:0]  Red,
    output logic [COLOR_WIDTH-1:0]  Green,
    output logic [COLOR_WIDTH-1:0]  Blue
);
    import vga_pkg::*;

    logic [CONFIG_WIDTH-1:0] h_cnt, v_cnt;
    logic [CONFIG_WIDTH-1:0] h_left, v_left, h_right, v_right;
    logic [CONFIG_WIDTH-1:0] h_sync, v_sync, h_max, v_max;
    logic [COLOR_WIDTH-1:0]  pix_r, pix_g, pix_b;
    logic h_wrap, v_wrap, frame_end, visible;
`ifdef VGA_TEST_PATTERN_EN
    logic pat_en;
`endif

    vga_config #(
        .CONFIG_WIDTH      (CONFIG_WIDTH),
        .H_Left_Margin_RD  (CONFIG_WIDTH'(H_LEFT_MARGIN_RD)),
        .V_Left_Margin_RD  (CONFIG_WIDTH'(V_LEFT_MARGIN_RD)),
        .H_Right_Margin_RD (CONFIG_WIDTH'(H_RIGHT_MARGIN_RD)),
        .V_Right_Margin_RD (CONFIG_WIDTH'(V_RIGHT_MARGIN_RD)),
        .H_Sync_Pulse_RD   (CONFIG_WIDTH'(H_SYNC_PULSE_RD)),
        .V_Sync_Pulse_RD   (CONFIG_WIDTH'(V_SYNC_PULSE_RD)),
        .H_Count_Max_RD    (CONFIG_WIDTH'(H_COUNT_MAX_RD)),
        .V_Count_Max_RD    (CONFIG_WIDTH'(V_COUNT_MAX_RD))
    ) config1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_valid   (C_valid),
        .c_addr    (C_addr),
        .c_data    (C_data),
        .frame_end (frame_end),
        .c_rdy     (C_rdy),
        .h_left    (h_left),
        .v_left    (v_left),
        .h_right   (h_right),
        .v_right   (v_right),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .h_max     (h_max),
`ifdef VGA_TEST_PATTERN_EN
        .pat_en    (pat_en),
`endif
        .v_max     (v_max)
    );

    // >= keeps the counters bounded even if a max shrinks below them.
    assign h_wrap    = h_cnt >= h_max;
    assign v_wrap    = v_cnt >= v_max;
    assign frame_end = h_wrap && v_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign visible = (h_cnt >= h_left) && (h_cnt < h_right) &&
                     (v_cnt >= v_left) && (v_cnt < v_right);

    always_comb begin
        pix_r = Data_in[3*COLOR_WIDTH-1 -: COLOR_WIDTH];
        pix_g = Data_in[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
        pix_b = Data_in[COLOR_WIDTH-1 -: COLOR_WIDTH];
`ifdef VGA_TEST_PATTERN_EN
        if (pat_en) begin
            pix_r = COLOR_WIDTH'(h_cnt);
            pix_g = COLOR_WIDTH'(v_cnt);
            pix_b = COLOR_WIDTH'(h_cnt ^ v_cnt);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HSync <= 1'b1;
            VSync <= 1'b1;
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
        end else begin
            HSync <= !(h_cnt < h_sync);
            VSync <= !(v_cnt < v_sync);
            Red   <= visible ? pix_r : '0;
            Green <= visible ? pix_g : '0;
            Blue  <= visible ? pix_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_control.sv
// Directed self-checking bench for vga_control.
// Pattern checks are compiled only with VGA_TEST_PATTERN_EN.
module tb_vga_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        C_valid = 1'b0;
    logic [3:0]  C_addr = 4'd0;
    logic [3:0]  C_data = 4'd0;
    logic [11:0] Data_in = 12'hAFA;
    logic        C_rdy, HSync, VSync;
    logic [3:0]  Red, Green, Blue;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int exp_hsp = 1;
    int exp_vsp = 0;
    logic [11:0] exp_rgb = 12'hAFA;
    int hs_low, vs_low, vis_cnt;

    vga_control dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .C_valid (C_valid),
        .C_addr  (C_addr),
        .C_data  (C_data),
        .Data_in (Data_in),
        .C_rdy   (C_rdy),
        .HSync   (HSync),
        .VSync   (VSync),
        .Red     (Red),
        .Green   (Green),
        .Blue    (Blue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Default geometry: 11-cycle lines, 13 lines, visible h 1..6, v 2..7.
    function automatic logic [13:0] exp_px(input int s);
        int p, h, v;
        logic vis;
        p = s % 143;
        h = p % 11;
        v = p / 11;
        vis = (h >= 1) && (h < 7) && (v >= 2) && (v < 8);
        return {h >= exp_hsp, v >= exp_vsp, vis ? exp_rgb : 12'h000};
    endfunction

    task automatic run_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            tick();
            chk($sformatf("pix s=%0d", n - 1),
                32'({HSync, VSync, Red, Green, Blue}), 32'(exp_px(n - 1)));
            if (!HSync) hs_low++;
            if (!VSync) vs_low++;
            if ({Red, Green, Blue} != 12'h000) vis_cnt++;
        end
    endtask

    task automatic clear_stats();
        hs_low = 0;
        vs_low = 0;
        vis_cnt = 0;
    endtask

    task automatic write_cfg(input logic [3:0] a, input logic [3:0] d);
        C_valid = 1'b1;
        C_addr = a;
        C_data = d;
        run_cycles(1);
        C_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", C_rdy, 0);
        chk("rst_hs", HSync, 1);
        chk("rst_vs", VSync, 1);
        chk("rst_rgb", {Red, Green, Blue}, 0);

        rst_n = 1'b1;
        n = 0;
        run_cycles(1);
        chk("rdy_after_rst", C_rdy, 1);
        run_cycles(142);
        clear_stats();
        run_cycles(143);
        chk("f1_hs_low", hs_low, 13);
        chk("f1_vs_low", vs_low, 0);
        chk("f1_visible", vis_cnt, 36);

        run_cycles(50);
        write_cfg(4'd5, 4'd2);
        chk("vsync_wr_rdy0", C_rdy, 0);
        run_cycles(428 - n);
        chk("rdy_before_end", C_rdy, 0);
        run_cycles(1);
        chk("rdy_after_end", C_rdy, 1);
        exp_vsp = 2;
        clear_stats();
        run_cycles(143);
        chk("f2_hs_low", hs_low, 13);
        chk("f2_vs_low", vs_low, 22);
        chk("f2_visible", vis_cnt, 36);

        Data_in = 12'hEF0;
        exp_rgb = 12'hEF0;
        write_cfg(4'd11, 4'd2);
        chk("unmapped11_rdy", C_rdy, 1);
`ifndef VGA_TEST_PATTERN_EN
        write_cfg(4'd8, 4'd1);
        chk("unmapped8_rdy", C_rdy, 1);
`endif
        run_cycles(143 - (n % 143));
        clear_stats();
        run_cycles(143);
        chk("f3_hs_low", hs_low, 13);
        chk("f3_vs_low", vs_low, 22);
        chk("f3_visible", vis_cnt, 36);

        run_cycles(30);
        write_cfg(4'd4, 4'd3);
        chk("hsync_wr_rdy0", C_rdy, 0);
        run_cycles(5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", C_rdy, 0);
        chk("mid_rst_hs", HSync, 1);
        chk("mid_rst_vs", VSync, 1);
        chk("mid_rst_rgb", {Red, Green, Blue}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        exp_vsp = 0;
        exp_hsp = 1;
        run_cycles(1);
        chk("rdy_after_rst2", C_rdy, 1);
        run_cycles(142);
        clear_stats();
        run_cycles(143);
        chk("f4_hs_low", hs_low, 13);
        chk("f4_vs_low", vs_low, 0);
        chk("f4_visible", vis_cnt, 36);

`ifdef VGA_TEST_PATTERN_EN
        C_valid = 1'b1;
        C_addr = 4'd8;
        C_data = 4'd1;
        tick();
        C_valid = 1'b0;
        chk("pat_rdy", C_rdy, 1);
        for (int i = 0; i < 300; i++) begin
            tick();
            if ((n - 1) % 143 == 47) break;
        end
        chk("pat_pos", (n - 1) % 143, 47);
        chk("pat_h3_v4", {Red, Green, Blue}, 12'h347);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
